// File: rtl/m10k_stream_port.sv
// Burst sequencer in front of the M10K wrapper: one command becomes a run of single-word
// accesses; a small FIFO absorbs the RAM read latency when the consumer applies backpressure.
module m10k_stream_port #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset_L,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W:0]  FIFO_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_beat;
   logic [ADDR_W:0]   r_issued;
   logic [RD_LAT-1:0] r_rd_pipe;
   logic [CNT_W-1:0]  r_inflight;
   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];

   logic              w_cmd_fire;
   logic              w_push;
   logic              w_pop;
   logic              w_last_beat;
   logic [ADDR_W:0]   w_len_sat;
   logic [CNT_W:0]    w_occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_len_sat   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
   assign w_cmd_fire  = cmd_valid & cmd_ready;
   assign out_valid   = (r_count != '0);
   assign out_data    = out_valid ? r_fifo[r_rptr] : '0;
   assign w_pop       = out_valid & out_ready;
   assign w_push      = r_rd_pipe[RD_LAT-1];
   assign w_last_beat = (r_beat == r_len - 1'b1);

   // Slots committed after this cycle's pop: words in flight plus words already buffered.
   assign w_occ = ({1'b0, r_inflight} + {1'b0, r_count}) - {{CNT_W{1'b0}}, w_pop};

   always_comb begin
      w_state_nxt   = r_state;
      cmd_ready     = 1'b0;
      in_ready      = 1'b0;
      done          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (w_len_sat == '0) w_state_nxt = S_DONE;
               else if (cmd_rw)     w_state_nxt = S_WRITE;
               else                 w_state_nxt = S_READ;
            end
         end
         S_WRITE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mem_write     = 1'b1;
               mem_address   = r_base + r_beat[ADDR_W-1:0];
               mem_writedata = in_data;
               if (w_last_beat) w_state_nxt = S_DONE;
            end
         end
         S_READ: begin
            if ((r_issued < r_len) && (w_occ < FIFO_LIM)) begin
               mem_read    = 1'b1;
               mem_address = r_base + r_issued[ADDR_W-1:0];
            end
            if (w_pop && w_last_beat) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_beat     <= '0;
         r_issued   <= '0;
         r_rd_pipe  <= '0;
         r_inflight <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(mem_read);
         if (w_cmd_fire) begin
            r_base   <= cmd_base;
            r_len    <= w_len_sat;
            r_beat   <= '0;
            r_issued <= '0;
         end else begin
            // Beats count accepted writes in WRITE and popped words in READ.
            if (mem_write || w_pop) r_beat <= r_beat + 1'b1;
            if (mem_read)           r_issued <= r_issued + 1'b1;
         end
         case ({mem_read, w_push})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_fifo[r_wptr] <= mem_readdata;
   end

endmodule
